// File: rtl/common_dffram_arb_pkg.sv
// Shared definitions for the DFF-RAM port-A arbiter.
package common_dffram_arb_pkg;

  // Controller state: serving requesters or sweeping the RAM with FLUSH_VALUE.
  typedef enum logic {
    SERVE = 1'b0,
    FLUSH = 1'b1
  } arb_state_e;

endpackage

// File: rtl/common_rr_arbiter_2.sv
// Two-way round-robin arbiter. The 1-bit pointer favours one requester when
// both are asking; after any grant it moves to the requester that lost out.
module common_rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer moves to the non-granted requester whenever a grant is issued.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = 1'b1;
    else if (gnt[1]) ptr_d = 1'b0;
  end

  // Pointer register; requester 0 is favoured out of reset.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/common_dffram_porta_arb.sv
// Port-A front end for a DFF RAM: arbitrates two requesters onto a single
// RAM port with read latency 1, and sweeps the whole RAM with FLUSH_VALUE on
// request or automatically out of reset. Flush has priority over requests.
module common_dffram_porta_arb
  import common_dffram_arb_pkg::*;
#(
  parameter int                        RAM_DATA_WIDTH = 8,
  parameter int                        RAM_DEPTH      = 16,
  parameter logic [RAM_DATA_WIDTH-1:0] FLUSH_VALUE    = '0,
  parameter bit                        AUTO_FLUSH     = 1'b1,
  localparam int                       AW             = $clog2(RAM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid_0,
  output logic                      req_ready_0,
  input  logic                      req_write_0,
  input  logic [AW-1:0]             req_addr_0,
  input  logic [RAM_DATA_WIDTH-1:0] req_wdata_0,
  input  logic                      req_valid_1,
  output logic                      req_ready_1,
  input  logic                      req_write_1,
  input  logic [AW-1:0]             req_addr_1,
  input  logic [RAM_DATA_WIDTH-1:0] req_wdata_1,
  output logic                      rsp_valid_0,
  output logic                      rsp_valid_1,
  output logic [RAM_DATA_WIDTH-1:0] rsp_data,
  input  logic                      flush_req,
  output logic                      flush_busy,
  output logic [AW-1:0]             ram_addra,
  output logic                      ram_ena,
  output logic                      ram_wea,
  output logic [RAM_DATA_WIDTH-1:0] ram_dina,
  input  logic [RAM_DATA_WIDTH-1:0] ram_douta
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  arb_state_e                state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [1:0]                rsp_valid_q;
  logic [RAM_DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]                gnt;
  logic [1:0]                rd_gnt;
  logic                      arb_en;

  // Requests are only considered while serving, out of reset, with no flush pending.
  assign arb_en = (state_q == SERVE) && !flush_req && !reset;

  common_rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req_valid_1, req_valid_0}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign rd_gnt = gnt & {~req_write_1, ~req_write_0};

  // Next-state and RAM port drive; the port is quiet while reset is held.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (!reset) begin
      case (state_q)
        SERVE: begin
          if (flush_req) begin
            state_d = FLUSH;
          end else if (gnt[1]) begin
            ram_ena   = 1'b1;
            ram_wea   = req_write_1;
            ram_addra = req_addr_1;
            ram_dina  = req_wdata_1;
          end else if (gnt[0]) begin
            ram_ena   = 1'b1;
            ram_wea   = req_write_0;
            ram_addra = req_addr_0;
            ram_dina  = req_wdata_0;
          end
        end
        FLUSH: begin
          ram_ena   = 1'b1;
          ram_wea   = 1'b1;
          ram_addra = cnt_q;
          ram_dina  = FLUSH_VALUE;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = SERVE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        default: state_d = SERVE;
      endcase
    end
  end

  // State and flush counter registers; reset re-arms the auto flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= AUTO_FLUSH ? FLUSH : SERVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read response: capture the combinational RAM output one cycle after a read grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_gnt;
      if (|rd_gnt) rsp_data_q <= ram_douta;
    end
  end

  // Outputs are forced idle while reset is held, even if a response is in flight.
  assign req_ready_0 = gnt[0];
  assign req_ready_1 = gnt[1];
  assign rsp_valid_0 = rsp_valid_q[0] && !reset;
  assign rsp_valid_1 = rsp_valid_q[1] && !reset;
  assign rsp_data    = reset ? '0 : rsp_data_q;
  assign flush_busy  = (state_q == FLUSH) && !reset;

endmodule

// File: tb/tb_common_dffram_porta_arb.sv
// Bench for common_dffram_porta_arb: behavioural RAM on port A, a cycle-level
// reference model of arbitration/flush, and a response scoreboard.
module tb_common_dffram_porta_arb;

  localparam int         DW    = 8;
  localparam int         DEPTH = 6;
  localparam int         AW    = 3;
  localparam logic [7:0] FV    = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid_0 = 0, req_write_0 = 0, req_valid_1 = 0, req_write_1 = 0;
  logic [AW-1:0] req_addr_0 = '0, req_addr_1 = '0;
  logic [DW-1:0] req_wdata_0 = '0, req_wdata_1 = '0;
  logic          flush_req = 0;
  logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, flush_busy;
  logic [DW-1:0] rsp_data, ram_dina, ram_douta;
  logic [AW-1:0] ram_addra;
  logic          ram_ena, ram_wea;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  common_dffram_porta_arb #(
    .RAM_DATA_WIDTH (DW),
    .RAM_DEPTH      (DEPTH),
    .FLUSH_VALUE    (FV),
    .AUTO_FLUSH     (1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_write_0(req_write_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_write_1(req_write_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1), .rsp_data(rsp_data),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .ram_addra(ram_addra), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  // Behavioural RAM: combinational read, synchronous write. Starts non-zero so
  // a missing flush write is visible.
  logic [DW-1:0] tb_ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) tb_ram[i] = 8'hEE;
  always @(posedge clk) if (ram_ena && ram_wea && ram_addra < DEPTH) tb_ram[ram_addra] <= ram_dina;
  assign ram_douta = (ram_addra < DEPTH) ? tb_ram[ram_addra] : 8'h00;

  // Reference model state.
  typedef struct { bit id; logic [DW-1:0] d; } rsp_t;
  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            flush_left = 0;
  bit            rr_fav = 0;
  bit            pend_v = 0;
  rsp_t          pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the model,
  // advance the model to what should hold after the next edge.
  task automatic cycle(input bit rst, input bit fr,
                       input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit e_r0, e_r1, e_busy, e_ena, e_wea, chk_port;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    int g;
    @(posedge clk); #1;
    reset = rst; flush_req = fr;
    req_valid_0 = v0; req_write_0 = w0; req_addr_0 = a0; req_wdata_0 = d0;
    req_valid_1 = v1; req_write_1 = w1; req_addr_1 = a1; req_wdata_1 = d1;
    if (pend_v && !rst) exp_q.push_back(pend);
    pend_v = 0;
    e_r0 = 0; e_r1 = 0; e_busy = 0; e_ena = 0; e_wea = 0;
    e_addr = '0; e_din = '0; chk_port = 1; g = -1;
    if (rst) begin
      flush_left = DEPTH;
      rr_fav = 0;
    end else if (flush_left > 0) begin
      e_busy = 1; e_ena = 1; e_wea = 1; e_din = FV;
      e_addr = AW'(DEPTH - flush_left);
      ref_mem[e_addr] = FV;
      flush_left--;
    end else if (fr) begin
      chk_port = 0;
      flush_left = DEPTH;
    end else begin
      chk_port = 0;
      if (v0 && v1) g = rr_fav;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
      if (g >= 0) begin
        e_r0 = (g == 0); e_r1 = (g == 1); e_ena = 1; chk_port = 1;
        e_wea  = (g == 0) ? w0 : w1;
        e_addr = (g == 0) ? a0 : a1;
        e_din  = (g == 0) ? d0 : d1;
        if (!e_wea) chk_port = 0;
        if (e_wea) ref_mem[e_addr] = e_din;
        else begin pend_v = 1; pend.id = (g == 1); pend.d = ref_mem[e_addr]; end
        rr_fav = (g == 0);
      end
    end
    #1;
    chk("req_ready_0", req_ready_0, e_r0);
    chk("req_ready_1", req_ready_1, e_r1);
    chk("flush_busy", flush_busy, e_busy);
    chk("ram_ena", ram_ena, e_ena);
    chk("ram_wea", ram_wea, e_wea);
    if (rst) begin
      chk("rst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
      chk("rst_rsp_data", rsp_data, 8'h00);
    end
    if (chk_port || (e_ena && !e_wea)) chk("ram_addra", ram_addra, e_addr);
    if (chk_port) chk("ram_dina", ram_dina, e_din);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Response monitor: pops expected reads whenever the DUT presents a response.
  logic [DW-1:0] last_data = '0;
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk); #4;
      if (reset) begin
        last_data = '0;
      end else if (rsp_valid_0 || rsp_valid_1) begin
        chk("rsp_onehot", rsp_valid_0 && rsp_valid_1, 1'b0);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: got valid=%0b%0b expected none", rsp_valid_1, rsp_valid_0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_valid_1, e.id);
          chk("rsp_data", rsp_data, e.d);
        end
        last_data = rsp_data;
      end else begin
        chk("rsp_hold", rsp_data, last_data);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hEE;
    // Reset, then auto flush over addresses 0..5.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(DEPTH);
    // Every entry reads back FLUSH_VALUE.
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0, AW'(i), '0, 0, 0, '0, '0);
    // Write A5 to addr 3 from requester 0, then read it from requester 1.
    cycle(0, 0, 1, 1, 3'd3, 8'hA5, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, '0, '0, 1, 0, 3'd3, '0);
    idle(1);
    // Fairness with both requesters continuously valid.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, AW'(i), '0, 1, 0, AW'(i + 1), '0);
    idle(1);
    // Flush request wins over a same-cycle request, which waits for SERVE.
    cycle(0, 1, 1, 1, 3'd2, 8'h3C, 0, 0, '0, '0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 1, 1, 3'd2, 8'h3C, 0, 0, '0, '0);
    idle(1);
    // Re-trigger during flush cycle 3 is ignored.
    cycle(0, 1, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(3);
    cycle(0, 1, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(DEPTH);
    // Reset at flush cycle 2, then a fresh flush from address 0.
    cycle(0, 1, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(2);
    cycle(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(DEPTH + 1);
    // Reset in the cycle after a read grant suppresses that response.
    cycle(0, 0, 1, 0, 3'd1, '0, 0, 0, '0, '0);
    cycle(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(DEPTH + 1);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit rr, ff;
      rr = ($urandom_range(0, 99) == 0);
      ff = ($urandom_range(0, 39) == 0);
      cycle(rr, ff,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    end
    idle(DEPTH + 3);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
